// File: rtl/koios_axi_pkg.sv
// koios_axi_pkg: shared AXI flit constants and types for the koios wrapper path
package koios_axi_pkg;
  localparam int AXI_DATAW = 128;
  localparam int DEST_W = 4;
  localparam int ID_W = 2;
  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [ID_W-1:0]      id;
    logic [AXI_DATAW-1:0] data;
  } axi_flit_t;
endpackage

// File: rtl/koios_sync_fifo.sv
// koios_sync_fifo: generic DEPTH x WIDTH register FIFO with occupancy count
module koios_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: entries are only read once counted
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/koios_axi_inp_buffer.sv
// koios_axi_inp_buffer: ordered ingress FIFO plus registered output stage feeding koios_axi_wrap
module koios_axi_inp_buffer
  import koios_axi_pkg::*;
#(
  parameter int AXI_DATAW = koios_axi_pkg::AXI_DATAW,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_DATAW-1:0]      s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DEST_W-1:0]         s_dest,
  input  logic [ID_W-1:0]           s_id,
  output logic [AXI_DATAW-1:0]      m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DEST_W-1:0]         m_dest,
  output logic [ID_W-1:0]           m_id,
  output logic [$clog2(DEPTH)+1:0]  level,
  output logic [CNT_W-1:0]          in_count,
  output logic [CNT_W-1:0]          out_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [ID_W-1:0]      id;
    logic [AXI_DATAW-1:0] data;
  } flit_t;
  flit_t wr_flit, rd_flit, m_flit_q, m_flit_d;
  logic push, pop, full, empty;
  logic [AW:0] fifo_count, next_count;
  logic s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic [CNT_W-1:0] in_count_q, in_count_d, out_count_q, out_count_d;
  koios_sync_fifo #(.WIDTH($bits(flit_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(wr_flit),
    .rdata(rd_flit),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  // s_ready looks at next-cycle occupancy so a full FIFO never sees a push
  always_comb begin
    push = s_valid && s_ready_q && !full;
    pop = (!m_valid_q || m_ready) && !empty;
    wr_flit = '{dest: s_dest, id: s_id, data: s_data};
    next_count = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    s_ready_d = next_count < (AW+1)'(DEPTH);
    m_valid_d = pop || (m_valid_q && !m_ready);
    m_flit_d = pop ? rd_flit : m_flit_q;
    in_count_d = in_count_q + CNT_W'(push);
    out_count_d = out_count_q + CNT_W'(m_valid_q && m_ready);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_flit_q <= '0;
      in_count_q <= '0;
      out_count_q <= '0;
    end else begin
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_flit_q <= m_flit_d;
      in_count_q <= in_count_d;
      out_count_q <= out_count_d;
    end
  end
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data = m_flit_q.data;
  assign m_dest = m_flit_q.dest;
  assign m_id = m_flit_q.id;
  assign level = (AW+2)'(fifo_count) + (AW+2)'(m_valid_q);
  assign in_count = in_count_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_koios_axi_inp_buffer.sv
// tb_koios_axi_inp_buffer: directed scoreboard bench for the ingress buffer
module tb_koios_axi_inp_buffer;
  localparam int DW = 128;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int FW = DW + 6;
  logic clk = 0, reset = 1;
  logic [DW-1:0] s_data = '0, m_data;
  logic s_valid = 0, s_ready, m_valid, m_ready = 0;
  logic [3:0] s_dest = '0, m_dest;
  logic [1:0] s_id = '0, m_id;
  logic [$clog2(DEPTH)+1:0] level;
  logic [CNT_W-1:0] in_count, out_count;
  int errors = 0, checks = 0;
  logic [FW-1:0] sb[$];
  int model_level = 0;
  logic [CNT_W-1:0] model_in = '0, model_out = '0;
  logic prev_stall = 0;
  logic [FW-1:0] prev_flit = '0;

  koios_axi_inp_buffer #(.AXI_DATAW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_dest(s_dest), .s_id(s_id), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_dest(m_dest), .m_id(m_id), .level(level), .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic [FW-1:0] f);
    {s_dest, s_id, s_data} = f;
  endtask

  task automatic send(input logic [FW-1:0] f);
    int g = 0;
    drive(f);
    s_valid = 1;
    while (!s_ready && g < 100) begin
      step();
      g++;
    end
    chk("send_ready", s_ready, 1);
    step();
    s_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    sb.delete();
    model_level = 0;
    model_in = '0;
    model_out = '0;
    prev_stall = 0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_s_ready", s_ready, 1);
    step();
    reset = 0;
  endtask

  // monitor: sample between edges, compare against scoreboard and occupancy model
  always @(negedge clk) begin
    if (!reset) begin
      chk("level", level, model_level);
      chk("in_count", in_count, model_in);
      chk("out_count", out_count, model_out);
      chk("level_vs_counters", CNT_W'(in_count - out_count), level);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_flit", {m_dest, m_id, m_data}, prev_flit);
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("out_flit", {m_dest, m_id, m_data}, sb.pop_front());
      end
      if (s_valid && s_ready) sb.push_back({s_dest, s_id, s_data});
      model_level = model_level + int'(s_valid && s_ready) - int'(m_valid && m_ready);
      model_in = model_in + CNT_W'(s_valid && s_ready);
      model_out = model_out + CNT_W'(m_valid && m_ready);
      prev_stall = m_valid && !m_ready;
      prev_flit = {m_dest, m_id, m_data};
    end
  end

  initial begin
    logic acc;
    int n, g;
    repeat (3) step();
    chk("reset_s_ready", s_ready, 1);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_dest", m_dest, 0);
    chk("reset_m_id", m_id, 0);
    chk("reset_level", level, 0);
    chk("reset_in_count", in_count, 0);
    chk("reset_out_count", out_count, 0);
    reset = 0;
    step();

    // single flit latency
    m_ready = 1;
    drive({4'd3, 2'd1, 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5});
    s_valid = 1;
    step();
    s_valid = 0;
    chk("single_m_valid_e1", m_valid, 0);
    chk("single_level_e1", level, 1);
    step();
    chk("single_m_valid_e2", m_valid, 1);
    chk("single_m_data", m_data, 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5);
    chk("single_m_dest", m_dest, 3);
    chk("single_m_id", m_id, 1);
    step();
    chk("single_m_valid_e3", m_valid, 0);
    chk("single_level_e3", level, 0);
    chk("single_in_count", in_count, 1);
    chk("single_out_count", out_count, 1);

    // fill with stalled output: five flits held, sixth waits upstream
    m_ready = 0;
    for (int k = 1; k <= 5; k++) send({4'(k), 2'(k), 128'(k * 32'h1111_1111)});
    chk("full_s_ready", s_ready, 0);
    chk("full_level", level, DEPTH + 1);
    drive({4'd6, 2'd2, 128'(6 * 32'h1111_1111)});
    s_valid = 1;
    repeat (3) step();
    chk("full_hold_s_ready", s_ready, 0);
    chk("full_hold_level", level, DEPTH + 1);
    chk("full_hold_in_count", in_count, 6);
    m_ready = 1;
    step();
    chk("drain_s_ready_rise", s_ready, 1);
    step();
    s_valid = 0;
    repeat (8) step();
    chk("drain_level", level, 0);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_in_count", in_count, 7);
    chk("drain_out_count", out_count, 7);

    // streaming with toggling m_ready
    drive(rnd_flit());
    s_valid = 1;
    m_ready = 0;
    for (int i = 0; i < 60; i++) begin
      acc = s_ready;
      step();
      m_ready = ~m_ready;
      if (acc) drive(rnd_flit());
    end
    s_valid = 0;
    m_ready = 1;
    repeat (10) step();
    chk("stream_level", level, 0);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_counts_equal", in_count, out_count);

    // asynchronous reset with three flits buffered
    m_ready = 0;
    for (int k = 0; k < 3; k++) send(rnd_flit());
    chk("pre_reset_level", level, 3);
    do_reset();
    m_ready = 1;
    send({4'hb, 2'd3, 128'hbeef});
    repeat (4) step();
    chk("post_reset_sb_empty", sb.size(), 0);
    chk("post_reset_in_count", in_count, 1);
    chk("post_reset_out_count", out_count, 1);

    // counter wrap: 65537 handshakes from reset
    do_reset();
    m_ready = 1;
    drive(rnd_flit());
    s_valid = 1;
    n = 0;
    g = 0;
    while (n < 65537 && g < 70000) begin
      acc = s_ready;
      if (acc) n++;
      step();
      if (acc) drive(rnd_flit());
      g++;
    end
    s_valid = 0;
    chk("wrap_accepts", n, 65537);
    repeat (4) step();
    chk("wrap_in_count", in_count, 1);
    chk("wrap_out_count", out_count, 1);
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
